mulacc_l2_cxu: RTL and testbench

Stateful multiply-accumulate custom function unit with a CFU-L2 streaming interface (valid/ready request and response channels, pipelined, back-pressurable). It holds one 32-bit accumulator per state context and sits behind the core's CFU request mux as a leaf target. A 1:1 mux stage in front of it passes all request and response fields through unchanged.

---
 rtl/mulacc_l2_cxu_pkg.sv | 18 +
 rtl/mulacc_l2_cxu_mux.sv | 45 ++++
 rtl/mulacc_l2_cxu_pipe.sv | 56 +++++
 rtl/mulacc_l2_cxu.sv | 135 +++++++++++++
 tb/tb_mulacc_l2_cxu.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/mulacc_l2_cxu_pkg.sv
// Shared encodings and width helpers for the multiply-accumulate CFU.
package mulacc_l2_cxu_pkg;

    typedef enum logic [2:0] {
        STATUS_OK          = 3'd0,
        STATUS_ERROR_FUNC  = 3'd1,
        STATUS_ERROR_STATE = 3'd2
    } cfu_status_e;

    localparam int unsigned FUNC_MULACC = 0;
    localparam int unsigned FUNC_CLEAR  = 1;

    // Index width for a field selecting one of n items; never narrower than 1 bit.
    function automatic int unsigned cfu_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mulacc_l2_cxu_mux.sv
// 1:1 CFU request/response mux stage: every field passes straight through.
module mux1_cfu #(
    parameter int unsigned CFU_ID_W  = 1,
    parameter int unsigned STATE_W   = 1,
    parameter int unsigned FUNC_ID_W = 10,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [CFU_ID_W-1:0]  req_cfu,
    input  logic [STATE_W-1:0]   req_state,
    input  logic [FUNC_ID_W-1:0] req_func,
    input  logic [DATA_W-1:0]    req_data0,
    input  logic [DATA_W-1:0]    req_data1,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2:0]           resp_status,
    output logic [DATA_W-1:0]    resp_data,

    output logic                 tgt_req_valid,
    input  logic                 tgt_req_ready,
    output logic [CFU_ID_W-1:0]  tgt_req_cfu,
    output logic [STATE_W-1:0]   tgt_req_state,
    output logic [FUNC_ID_W-1:0] tgt_req_func,
    output logic [DATA_W-1:0]    tgt_req_data0,
    output logic [DATA_W-1:0]    tgt_req_data1,
    input  logic                 tgt_resp_valid,
    output logic                 tgt_resp_ready,
    input  logic [2:0]           tgt_resp_status,
    input  logic [DATA_W-1:0]    tgt_resp_data
);

    assign tgt_req_valid  = req_valid;
    assign req_ready      = tgt_req_ready;
    assign tgt_req_cfu    = req_cfu;
    assign tgt_req_state  = req_state;
    assign tgt_req_func   = req_func;
    assign tgt_req_data0  = req_data0;
    assign tgt_req_data1  = req_data1;
    assign resp_valid     = tgt_resp_valid;
    assign tgt_resp_ready = resp_ready;
    assign resp_status    = tgt_resp_status;
    assign resp_data      = tgt_resp_data;

endmodule

// File: rtl/mulacc_l2_cxu_pipe.sv
// Stall-able valid/data/status delay line; any output back-pressure freezes every stage.
module mulacc_l2_pipe #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_status,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_status
);

    if (LATENCY == 0) begin : g_comb
        assign in_ready   = out_ready;
        assign out_valid  = in_valid;
        assign out_data   = in_data;
        assign out_status = in_status;
    end else begin : g_regs
        logic              v [LATENCY];
        logic [DATA_W-1:0] d [LATENCY];
        logic [2:0]        s [LATENCY];
        logic              stall;

        assign stall      = v[LATENCY-1] && !out_ready;
        assign in_ready   = !stall;
        assign out_valid  = v[LATENCY-1];
        assign out_data   = d[LATENCY-1];
        assign out_status = s[LATENCY-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < LATENCY; i++) begin
                    v[i] <= 1'b0;
                    d[i] <= '0;
                    s[i] <= '0;
                end
            end else if (clk_en && !stall) begin
                v[0] <= in_valid;
                d[0] <= in_valid ? in_data : '0;
                s[0] <= in_valid ? in_status : '0;
                for (int unsigned i = 1; i < LATENCY; i++) begin
                    v[i] <= v[i-1];
                    d[i] <= d[i-1];
                    s[i] <= s[i-1];
                end
            end
        end
    end

endmodule

// File: rtl/mulacc_l2_cxu.sv
// Stateful multiply-accumulate CFU (CFU-L2 streaming) behind a 1:1 request mux.
module mulacc_l2_cxu
    import mulacc_l2_cxu_pkg::*;
#(
    parameter int unsigned CFU_N_CFUS    = 2,
    parameter int unsigned CFU_N_STATES  = 1,
    parameter int unsigned CFU_FUNC_ID_W = 10,
    parameter int unsigned CFU_INSN_W    = 0,
    parameter int unsigned CFU_DATA_W    = 32,
    parameter int unsigned CFU_LATENCY   = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clk_en,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [cfu_idx_w(CFU_N_CFUS)-1:0]      req_cfu,
    input  logic [cfu_idx_w(CFU_N_STATES)-1:0]    req_state,
    input  logic [CFU_FUNC_ID_W-1:0]              req_func,
    input  logic [CFU_DATA_W-1:0]                 req_data0,
    input  logic [CFU_DATA_W-1:0]                 req_data1,
    output logic                                  resp_valid,
    input  logic                                  resp_ready,
    output logic [2:0]                            resp_status,
    output logic [CFU_DATA_W-1:0]                 resp_data
);

    localparam int unsigned CFU_ID_W = cfu_idx_w(CFU_N_CFUS);
    localparam int unsigned STATE_W  = cfu_idx_w(CFU_N_STATES);

    logic                     t_valid, t_ready, t_resp_valid, t_resp_ready;
    logic [CFU_ID_W-1:0]      t_cfu;
    logic [STATE_W-1:0]       t_state;
    logic [CFU_FUNC_ID_W-1:0] t_func;
    logic [CFU_DATA_W-1:0]    t_data0, t_data1, t_resp_data;
    logic [2:0]               t_resp_status;

    mux1_cfu #(
        .CFU_ID_W  (CFU_ID_W),
        .STATE_W   (STATE_W),
        .FUNC_ID_W (CFU_FUNC_ID_W),
        .DATA_W    (CFU_DATA_W)
    ) u_mux (
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_cfu         (req_cfu),
        .req_state       (req_state),
        .req_func        (req_func),
        .req_data0       (req_data0),
        .req_data1       (req_data1),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_status     (resp_status),
        .resp_data       (resp_data),
        .tgt_req_valid   (t_valid),
        .tgt_req_ready   (t_ready),
        .tgt_req_cfu     (t_cfu),
        .tgt_req_state   (t_state),
        .tgt_req_func    (t_func),
        .tgt_req_data0   (t_data0),
        .tgt_req_data1   (t_data1),
        .tgt_resp_valid  (t_resp_valid),
        .tgt_resp_ready  (t_resp_ready),
        .tgt_resp_status (t_resp_status),
        .tgt_resp_data   (t_resp_data)
    );

    logic unused_cfu;
    assign unused_cfu = ^t_cfu;

    logic [CFU_DATA_W-1:0] acc [CFU_N_STATES];
    logic [CFU_DATA_W-1:0] acc_old, acc_new, prod, result;
    logic                  state_ok, wr, accept;
    cfu_status_e           status;

    assign state_ok = 32'(t_state) < CFU_N_STATES;
    assign prod     = t_data0 * t_data1;
    assign accept   = t_valid && t_ready && clk_en;

    // Loop select keeps the out-of-range state value from ever indexing the array.
    always_comb begin
        acc_old = '0;
        for (int unsigned i = 0; i < CFU_N_STATES; i++) begin
            if (32'(t_state) == i) acc_old = acc[i];
        end
    end

    always_comb begin
        status  = STATUS_OK;
        result  = '0;
        acc_new = acc_old;
        wr      = 1'b0;
        if (!state_ok) begin
            status = STATUS_ERROR_STATE;
        end else if (32'(t_func) == FUNC_MULACC) begin
            acc_new = acc_old + prod;
            result  = acc_new;
            wr      = 1'b1;
        end else if (32'(t_func) == FUNC_CLEAR) begin
            acc_new = '0;
            result  = acc_old;
            wr      = 1'b1;
        end else begin
            status = STATUS_ERROR_FUNC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CFU_N_STATES; i++) acc[i] <= '0;
        end else if (accept && wr) begin
            for (int unsigned i = 0; i < CFU_N_STATES; i++) begin
                if (32'(t_state) == i) acc[i] <= acc_new;
            end
        end
    end

    mulacc_l2_pipe #(
        .LATENCY (CFU_LATENCY),
        .DATA_W  (CFU_DATA_W)
    ) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .in_valid   (t_valid),
        .in_ready   (t_ready),
        .in_data    (result),
        .in_status  (status),
        .out_valid  (t_resp_valid),
        .out_ready  (t_resp_ready),
        .out_data   (t_resp_data),
        .out_status (t_resp_status)
    );

endmodule

// File: tb/tb_mulacc_l2_cxu.sv
// Directed bench for mulacc_l2_cxu at latency 1, one state context.
module tb_mulacc_l2_cxu;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, req_valid, req_ready, resp_valid, resp_ready;
    logic [0:0]  req_cfu, req_state;
    logic [9:0]  req_func;
    logic [31:0] req_data0, req_data1, resp_data;
    logic [2:0]  resp_status;

    int n_checks = 0;
    int n_fail   = 0;

    mulacc_l2_cxu #(
        .CFU_N_CFUS    (2),
        .CFU_N_STATES  (1),
        .CFU_FUNC_ID_W (10),
        .CFU_INSN_W    (0),
        .CFU_DATA_W    (32),
        .CFU_LATENCY   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cfu     (req_cfu),
        .req_state   (req_state),
        .req_func    (req_func),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_status (resp_status),
        .resp_data   (resp_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic st, input logic [9:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        req_valid = v;
        req_state = st;
        req_func  = f;
        req_data0 = a;
        req_data1 = b;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_resp(input string tag, input logic [31:0] data, input logic [2:0] st);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_data"}, resp_data, data);
        check({tag, "_status"}, 32'(resp_status), 32'(st));
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; resp_ready = 1'b1; req_cfu = 1'b0;
        drive(1'b0, 1'b0, 10'd0, 32'd0, 32'd0);
        step(); step();
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_status", 32'(resp_status), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // back-to-back MULACC, CLEAR, MULACC
        drive(1'b1, 1'b0, 10'd0, 32'd3, 32'd4); step(); check_resp("mac_3x4", 32'd12, 3'd0);
        drive(1'b1, 1'b0, 10'd0, 32'd5, 32'd6); step(); check_resp("mac_5x6", 32'd42, 3'd0);
        drive(1'b1, 1'b0, 10'd1, 32'd9, 32'd9); step(); check_resp("clear_old", 32'd42, 3'd0);
        drive(1'b1, 1'b0, 10'd0, 32'd2, 32'd2); step(); check_resp("mac_2x2", 32'd4, 3'd0);
        drive(1'b1, 1'b0, 10'd1, 32'd0, 32'd0); step(); check_resp("clear_4", 32'd4, 3'd0);

        // modular wrap
        drive(1'b1, 1'b0, 10'd0, 32'hFFFF_FFFF, 32'd2); step(); check_resp("wrap_a", 32'hFFFF_FFFE, 3'd0);
        drive(1'b1, 1'b0, 10'd0, 32'd1, 32'd2); step(); check_resp("wrap_b", 32'h0000_0000, 3'd0);

        // error paths leave the accumulator alone
        drive(1'b1, 1'b0, 10'd0, 32'd1, 32'd3); step(); check_resp("mac_1x3", 32'd3, 3'd0);
        drive(1'b1, 1'b0, 10'd7, 32'd5, 32'd5); step(); check_resp("err_func", 32'd0, 3'd1);
        drive(1'b1, 1'b0, 10'd0, 32'd0, 32'd0); step(); check_resp("after_errf", 32'd3, 3'd0);
        drive(1'b1, 1'b1, 10'd0, 32'd10, 32'd10); step(); check_resp("err_state", 32'd0, 3'd2);
        drive(1'b1, 1'b1, 10'd7, 32'd1, 32'd1); step(); check_resp("err_prio", 32'd0, 3'd2);
        drive(1'b1, 1'b1, 10'd1, 32'd0, 32'd0); step(); check_resp("err_clr", 32'd0, 3'd2);
        drive(1'b1, 1'b0, 10'd0, 32'd0, 32'd0); step(); check_resp("after_errs", 32'd3, 3'd0);
        drive(1'b0, 1'b0, 10'd0, 32'd0, 32'd0); step();
        check("idle_valid", 32'(resp_valid), 32'd0);

        // back-pressure: three requests, resp_ready low for three cycles
        resp_ready = 1'b0;
        drive(1'b1, 1'b0, 10'd0, 32'd1, 32'd1); step();
        check_resp("bp_r1_c1", 32'd4, 3'd0);
        check("bp_ready_c1", 32'(req_ready), 32'd0);
        drive(1'b1, 1'b0, 10'd0, 32'd1, 32'd1); step();
        check_resp("bp_r1_c2", 32'd4, 3'd0);
        check("bp_ready_c2", 32'(req_ready), 32'd0);
        step();
        check_resp("bp_r1_c3", 32'd4, 3'd0);
        check("bp_ready_c3", 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        #1;
        check("bp_ready_rel", 32'(req_ready), 32'd1);
        step(); check_resp("bp_r2", 32'd5, 3'd0);
        drive(1'b1, 1'b0, 10'd0, 32'd2, 32'd1); step(); check_resp("bp_r3", 32'd7, 3'd0);

        // clk_en low: nothing accepted, nothing moves
        clk_en = 1'b0;
        drive(1'b1, 1'b0, 10'd0, 32'd1, 32'd1); step();
        check_resp("cen_hold", 32'd7, 3'd0);
        step();
        check_resp("cen_hold2", 32'd7, 3'd0);
        clk_en = 1'b1;
        step(); check_resp("cen_resume", 32'd8, 3'd0);

        // reset with a response in flight
        drive(1'b1, 1'b0, 10'd0, 32'd5, 32'd5); step();
        check_resp("pre_rst", 32'd33, 3'd0);
        drive(1'b0, 1'b0, 10'd0, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(resp_valid), 32'd0);
        check("midrst_data", resp_data, 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 10'd0, 32'd1, 32'd1); step(); check_resp("post_rst", 32'd1, 3'd0);
        drive(1'b0, 1'b0, 10'd0, 32'd0, 32'd0); step();
        check("final_idle", 32'(resp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
